// File: rtl/esc_pwm_decoder.sv
// esc_pwm_decoder: measures the high time of one ESC PWM line and recovers the
// 11-bit SPEED that produced it (pulse = MIN_PULSE + SCALE*SPEED clocks).
// A timeout counter flags the line as stale when no rising edge arrives.
module esc_pwm_decoder #(
    parameter int MIN_PULSE = 50000,
    parameter int SCALE     = 3,
    parameter int CNT_W     = 17,
    parameter int TIMEOUT   = 2097152
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm_in,
    output logic [10:0] speed,
    output logic        vld,
    output logic        rng_err,
    output logic        stale
);

    // Divider datapath is wide enough to hold the excess and SCALE<<10.
    localparam int DW = CNT_W + 12;
    // The timeout counter must be able to reach TIMEOUT itself.
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [DW-1:0] MIN_X   = DW'(MIN_PULSE);
    localparam logic [DW-1:0] SPAN_X  = DW'(SCALE * 2048);
    localparam logic [DW-1:0] DVS_TOP = DW'(SCALE * 1024);
    localparam logic [TW-1:0] TO_LIM  = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, HIGH, CHK, DIV} state_t;

    logic             sync1_q, sync2_q, prev_q;
    logic             rise, fall;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [DW-1:0]    rem_q, rem_d;
    logic [DW-1:0]    dvs_q, dvs_d;
    logic [9:0]       quo_q, quo_d;
    logic [3:0]       bit_q, bit_d;
    logic             err_q, err_d;
    logic             ovr_q, ovr_d;
    logic [10:0]      speed_q, speed_d;
    logic             vld_q, vld_d;
    logic             rng_err_q, rng_err_d;
    logic [TW-1:0]    to_cnt_q, to_cnt_d;
    logic [DW-1:0]    width_x, excess;
    logic             q_bit;

    // Two-flop synchronizer plus edge-detect history, reset high so a pulse
    // already in progress at reset release never produces a rising edge.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours, exactly like the real register chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~prev_q;
    assign fall = ~sync2_q & prev_q;

    // Next-state logic: pulse measurement, range check and 11-step restoring divide.
    // NOTE: every signal driven here gets a default first, otherwise paths that
    // do not assign it would infer a latch.
    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        bit_d     = bit_q;
        err_d     = err_q;
        ovr_d     = ovr_q;
        speed_d   = speed_q;
        rng_err_d = rng_err_q;
        vld_d     = 1'b0;
        q_bit     = 1'b0;

        width_x = {{(DW - CNT_W){1'b0}}, width_q};
        excess  = width_x - MIN_X;

        // Any synced rise restarts the timeout window, whatever the FSM is doing.
        if (rise) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == '1) begin
            to_cnt_d = to_cnt_q;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                // The cycle that shows the rise is itself a high sample.
                if (rise) begin
                    width_d = CNT_W'(1);
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d = CHK;
                end else if (sync2_q && (width_q != '1)) begin
                    width_d = width_q + CNT_W'(1);
                end
            end
            CHK: begin
                // Out-of-range widths divide zero so the latency stays fixed.
                bit_d   = '0;
                quo_d   = '0;
                dvs_d   = DVS_TOP;
                err_d   = 1'b0;
                ovr_d   = 1'b0;
                rem_d   = excess;
                state_d = DIV;
                if (width_x < MIN_X) begin
                    err_d = 1'b1;
                    rem_d = '0;
                end else if ((excess >= SPAN_X) || (width_q == '1)) begin
                    err_d = 1'b1;
                    ovr_d = 1'b1;
                    rem_d = '0;
                end
            end
            DIV: begin
                // Trial-subtract SCALE<<i for i = 10 down to 0; keep it if it fits.
                if (rem_q >= dvs_q) begin
                    rem_d = rem_q - dvs_q;
                    q_bit = 1'b1;
                end
                quo_d = {quo_q[8:0], q_bit};
                dvs_d = dvs_q >> 1;
                bit_d = bit_q + 4'd1;
                if (bit_q == 4'd10) begin
                    state_d   = IDLE;
                    vld_d     = 1'b1;
                    rng_err_d = err_q;
                    speed_d   = err_q ? {11{ovr_q}} : {quo_q, q_bit};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; the timeout counter starts saturated so
    // the line reads stale until the first rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            width_q   <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            quo_q     <= '0;
            bit_q     <= '0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
            speed_q   <= '0;
            vld_q     <= 1'b0;
            rng_err_q <= 1'b0;
            to_cnt_q  <= '1;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            quo_q     <= quo_d;
            bit_q     <= bit_d;
            err_q     <= err_d;
            ovr_q     <= ovr_d;
            speed_q   <= speed_d;
            vld_q     <= vld_d;
            rng_err_q <= rng_err_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign speed   = speed_q;
    assign vld     = vld_q;
    assign rng_err = rng_err_q;
    assign stale   = (to_cnt_q >= TO_LIM);

endmodule

// File: tb/tb_esc_pwm_decoder.sv
// tb_esc_pwm_decoder: directed and randomized pulse widths checked against an
// arithmetic reference model of the pulse-to-speed rule, plus stale/reset cases.
module tb_esc_pwm_decoder;

    localparam int MIN_PULSE = 64;
    localparam int SCALE     = 3;
    localparam int CNT_W     = 13;
    localparam int TIMEOUT   = 4096;
    localparam int MAX_W     = (1 << CNT_W) - 1;
    // vld appears 14 edges after the first low-sampling edge (edge n+1).
    localparam int LAT       = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        pwm_in;
    logic [10:0] speed;
    logic        vld;
    logic        rng_err;
    logic        stale;

    int          checks = 0;
    int          errors = 0;
    int          vld_cnt;
    int          vld_at;
    logic [10:0] got_speed;
    logic        got_err;
    logic        stale_hist[$];

    always #5 clk = ~clk;

    esc_pwm_decoder #(
        .MIN_PULSE(MIN_PULSE),
        .SCALE    (SCALE),
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .speed  (speed),
        .vld    (vld),
        .rng_err(rng_err),
        .stale  (stale)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference rule: width saturates at all-ones; below MIN -> 0/err,
    // at or beyond the 2048-step span (or saturated) -> 2047/err, else floor.
    function automatic void model(input int n, output int sp, output int er);
        int w;
        w = (n > MAX_W) ? MAX_W : n;
        if (w < MIN_PULSE) begin
            sp = 0;
            er = 1;
        end else if ((w == MAX_W) || ((w - MIN_PULSE) >= SCALE * 2048)) begin
            sp = 2047;
            er = 1;
        end else begin
            sp = (w - MIN_PULSE) / SCALE;
            er = 0;
        end
    endfunction

    // Called just after a falling clk edge. Drives the line high for n rising
    // edges, then low for tail edges; an optional second pulse spans edges
    // g_on+1..g_off. Records vld activity and stale after every edge k.
    task automatic drive_pulse(input int n, input int tail, input int g_on, input int g_off);
        pwm_in  = 1'b1;
        vld_cnt = 0;
        vld_at  = 0;
        stale_hist.delete();
        for (int k = 1; k <= n + tail; k++) begin
            @(negedge clk);
            stale_hist.push_back(stale);
            if (vld === 1'b1) begin
                vld_cnt++;
                if (vld_cnt == 1) begin
                    vld_at    = k;
                    got_speed = speed;
                    got_err   = rng_err;
                end
            end
            if (k == n)     pwm_in = 1'b0;
            if (k == g_on)  pwm_in = 1'b1;
            if (k == g_off) pwm_in = 1'b0;
        end
    endtask

    task automatic pulse_check(input string tag, input int n);
        int sp;
        int er;
        model(n, sp, er);
        drive_pulse(n, 20, 0, 0);
        check({tag, "/vld_cnt"}, vld_cnt, 1);
        check({tag, "/latency"}, vld_at, n + LAT);
        check({tag, "/speed"}, got_speed, sp);
        check({tag, "/rng_err"}, got_err, er);
    endtask

    initial begin
        int lb_speeds[4];
        int n;
        int stray;

        // Reset values.
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset/speed", speed, 0);
        check("reset/vld", vld, 0);
        check("reset/rng_err", rng_err, 0);
        check("reset/stale", stale, 1);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Minimum legal pulse, floor behaviour, range edges.
        pulse_check("min_pulse", MIN_PULSE);
        pulse_check("mid_exact", MIN_PULSE + 3072);
        pulse_check("mid_floor", MIN_PULSE + 3074);
        pulse_check("under_range", MIN_PULSE - 1);
        pulse_check("top_legal", MIN_PULSE + SCALE * 2048 - 1);
        pulse_check("over_range", MIN_PULSE + SCALE * 2048);

        // Loopback of encoder-style pulses.
        lb_speeds = '{0, 1, 1000, 2047};
        foreach (lb_speeds[i]) begin
            pulse_check($sformatf("loopback_%0d", lb_speeds[i]), MIN_PULSE + SCALE * lb_speeds[i]);
        end

        // Random widths, including some below the legal minimum.
        for (int i = 0; i < 8; i++) begin
            n = int'($urandom_range(40, 2500));
            pulse_check($sformatf("rand_%0d_w%0d", i, n), n);
        end

        // Idle low for TIMEOUT: stale rises exactly TIMEOUT edges after the
        // clearing edge (rise seen through 2 sync flops, cleared on edge 3).
        drive_pulse(MIN_PULSE + SCALE * 7, TIMEOUT + 5, 0, 0);
        check("idle/vld_cnt", vld_cnt, 1);
        check("idle/speed", got_speed, 7);
        check("idle/stale_before_limit", stale_hist[TIMEOUT + 1], 0);
        check("idle/stale_at_limit", stale_hist[TIMEOUT + 2], 1);
        check("idle/speed_held", speed, 7);

        // Next rise clears stale on edge 3; its fall still decodes.
        drive_pulse(MIN_PULSE + SCALE * 10, 20, 0, 0);
        check("rearm/stale_edge2", stale_hist[1], 1);
        check("rearm/stale_edge3", stale_hist[2], 0);
        check("rearm/vld_cnt", vld_cnt, 1);
        check("rearm/latency", vld_at, MIN_PULSE + SCALE * 10 + LAT);
        check("rearm/speed", got_speed, 10);

        // Stuck-high line: width saturates, stale asserts, fall gives 2047/err.
        drive_pulse(9000, 20, 0, 0);
        check("stuck/stale_before_limit", stale_hist[TIMEOUT + 1], 0);
        check("stuck/stale_at_limit", stale_hist[TIMEOUT + 2], 1);
        check("stuck/vld_cnt", vld_cnt, 1);
        check("stuck/latency", vld_at, 9000 + LAT);
        check("stuck/speed", got_speed, 2047);
        check("stuck/rng_err", got_err, 1);

        // A pulse rising during CHK/DIV is dropped; only the first pulse decodes.
        n = MIN_PULSE + SCALE * 50;
        drive_pulse(n, 60, n + 3, n + 8);
        check("drop/vld_cnt", vld_cnt, 1);
        check("drop/latency", vld_at, n + LAT);
        check("drop/speed", got_speed, 50);
        check("drop/rng_err", got_err, 0);
        pulse_check("drop_rearm", MIN_PULSE + SCALE * 321);

        // Reset mid-pulse, released with the line still high: pulse is lost.
        stray  = 0;
        pwm_in = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (vld === 1'b1) stray++;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst/speed", speed, 0);
        check("midrst/vld", vld, 0);
        check("midrst/rng_err", rng_err, 0);
        check("midrst/stale", stale, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (vld === 1'b1) stray++;
        end
        pwm_in = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (vld === 1'b1) stray++;
        end
        check("midrst/no_vld", stray, 0);
        pulse_check("after_rst", MIN_PULSE + 3072);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
